// File: rtl/decade_run_ctrl.sv
// Run controller for a chain of cascaded BCD decade counters.
// Start/stop/clear sequencing, target compare and chain carry.
module decade_run_ctrl #(
   parameter int NDIG         = 2,
   parameter bit AUTO_RESTART = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              clear,
   input  logic              tick,
   input  logic [4*NDIG-1:0] target,
   output logic [4*NDIG-1:0] bcd,
   output logic              running,
   output logic              done,
   output logic              z,
   output logic              err
);

   localparam int W = 4 * NDIG;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } state_t;

   state_t         state;
   logic [W-1:0]   tgt;
   logic [W-1:0]   inc_bcd;
   logic           carry;
   logic           all9;
   logic           tgt_ok;
   logic           hit;

   // Ripple the decade carry: digit i moves only when all lower digits are 9
   always_comb begin
      inc_bcd = bcd;
      carry   = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (carry) begin
            if (bcd[4*i +: 4] == 4'd9)
               inc_bcd[4*i +: 4] = 4'd0;
            else
               inc_bcd[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
         end
         carry = carry && (bcd[4*i +: 4] == 4'd9);
      end
      all9 = carry;
   end

   always_comb begin
      tgt_ok = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (target[4*i +: 4] > 4'd9)
            tgt_ok = 1'b0;
      end
   end

   assign hit = (inc_bcd == tgt);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bcd     <= '0;
         tgt     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
         z       <= 1'b0;
         err     <= 1'b0;
      end else begin
         z   <= 1'b0;
         err <= 1'b0;
         if (AUTO_RESTART)
            done <= 1'b0;
         if (clear) begin
            state   <= IDLE;
            bcd     <= '0;
            done    <= 1'b0;
            running <= 1'b0;
         end else begin
            unique case (state)
               RUN: begin
                  if (stop) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end else if (tick) begin
                     z <= all9;
                     if (hit) begin
                        done <= 1'b1;
                        if (AUTO_RESTART) begin
                           bcd <= '0;
                        end else begin
                           bcd     <= tgt;
                           state   <= DONE;
                           running <= 1'b0;
                        end
                     end else begin
                        bcd <= inc_bcd;
                     end
                  end
               end
               PAUSE: begin
                  if (start) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               IDLE, DONE: begin
                  // DONE keeps its level if a restart is rejected
                  if (start) begin
                     if (tgt_ok) begin
                        tgt     <= target;
                        bcd     <= '0;
                        state   <= RUN;
                        running <= 1'b1;
                        done    <= 1'b0;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               default: begin
                  state   <= IDLE;
                  running <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_decade_run_ctrl.sv
// Bench for decade_run_ctrl: plain and auto-restart instances
// driven together, checked against a decimal reference model.
module tb_decade_run_ctrl;

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_DONE  = 3;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic       clear;
   logic       tick;
   logic [7:0] target;
   logic [7:0] bcd;
   logic       running;
   logic       done;
   logic       z;
   logic       err;
   logic [7:0] abcd;
   logic       arun;
   logic       adone;
   logic       az;
   logic       aerr;

   int checks = 0;
   int errors = 0;

   int   m_st[2];
   int   m_cnt[2];
   int   m_tgt[2];
   logic m_done[2];

   typedef struct {
      logic [7:0] bcd;
      logic       run;
      logic       done;
      logic       z;
      logic       err;
   } obs_t;

   typedef struct {
      obs_t m;
      obs_t a;
   } exp_t;

   exp_t sbq[$];

   decade_run_ctrl #(.NDIG(2), .AUTO_RESTART(1'b0)) u_dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .clear(clear), .tick(tick), .target(target), .bcd(bcd),
      .running(running), .done(done), .z(z), .err(err)
   );

   decade_run_ctrl #(.NDIG(2), .AUTO_RESTART(1'b1)) u_dut_ar (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .clear(clear), .tick(tick), .target(target), .bcd(abcd),
      .running(arun), .done(adone), .z(az), .err(aerr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k]   = S_IDLE;
         m_cnt[k]  = 0;
         m_tgt[k]  = 0;
         m_done[k] = 1'b0;
      end
   endtask

   task automatic model(input int k, input logic c, s, p, t,
                        input logic [7:0] tg, output obs_t o);
      int n;
      o.z   = 1'b0;
      o.err = 1'b0;
      if (k == 1) m_done[k] = 1'b0;
      if (c) begin
         m_st[k]   = S_IDLE;
         m_cnt[k]  = 0;
         m_done[k] = 1'b0;
      end else begin
         case (m_st[k])
            S_RUN: begin
               if (p) begin
                  m_st[k] = S_PAUSE;
               end else if (t) begin
                  n   = (m_cnt[k] + 1) % 100;
                  o.z = (m_cnt[k] == 99);
                  if (n == m_tgt[k]) begin
                     m_done[k] = 1'b1;
                     if (k == 1) begin
                        m_cnt[k] = 0;
                     end else begin
                        m_cnt[k] = n;
                        m_st[k]  = S_DONE;
                     end
                  end else begin
                     m_cnt[k] = n;
                  end
               end
            end
            S_PAUSE: if (s) m_st[k] = S_RUN;
            default: begin
               if (s) begin
                  if (tg[7:4] <= 4'd9 && tg[3:0] <= 4'd9) begin
                     m_tgt[k]  = int'(tg[7:4]) * 10 + int'(tg[3:0]);
                     m_cnt[k]  = 0;
                     m_st[k]   = S_RUN;
                     m_done[k] = 1'b0;
                  end else begin
                     o.err = 1'b1;
                  end
               end
            end
         endcase
      end
      o.bcd  = {4'(m_cnt[k] / 10), 4'(m_cnt[k] % 10)};
      o.run  = (m_st[k] == S_RUN);
      o.done = m_done[k];
   endtask

   task automatic cyc(input logic c, s, p, t, input logic [7:0] tg);
      exp_t e;
      exp_t g;
      @(negedge clk);
      clear  = c;
      start  = s;
      stop   = p;
      tick   = t;
      target = tg;
      model(0, c, s, p, t, tg, e.m);
      model(1, c, s, p, t, tg, e.a);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      g = sbq.pop_front();
      chk("bcd",   32'(bcd),     32'(g.m.bcd));
      chk("run",   32'(running), 32'(g.m.run));
      chk("done",  32'(done),    32'(g.m.done));
      chk("z",     32'(z),       32'(g.m.z));
      chk("err",   32'(err),     32'(g.m.err));
      chk("a_bcd", 32'(abcd),    32'(g.a.bcd));
      chk("a_run", 32'(arun),    32'(g.a.run));
      chk("a_done",32'(adone),   32'(g.a.done));
      chk("a_z",   32'(az),      32'(g.a.z));
      chk("a_err", 32'(aerr),    32'(g.a.err));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_bcd"},  32'(bcd),     32'h0);
      chk({tag, "_run"},  32'(running), 32'h0);
      chk({tag, "_done"}, 32'(done),    32'h0);
      chk({tag, "_z"},    32'(z),       32'h0);
      chk({tag, "_err"},  32'(err),     32'h0);
      chk({tag, "_abcd"}, 32'(abcd),    32'h0);
   endtask

   logic [7:0] seq5[7];

   initial begin
      seq5 = '{8'h01, 8'h02, 8'h00, 8'h01, 8'h02, 8'h00, 8'h01};
      reset  = 1'b1;
      start  = 1'b0;
      stop   = 1'b0;
      clear  = 1'b0;
      tick   = 1'b0;
      target = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("rst");
      @(negedge clk);
      reset = 1'b0;

      // 1: count to 12, then hold in DONE
      cyc(0, 1, 0, 0, 8'h12);
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 8'h00);
      chk("t1_bcd",  32'(bcd),     32'h12);
      chk("t1_done", 32'(done),    32'h1);
      chk("t1_run",  32'(running), 32'h0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'h00);
      cyc(0, 0, 1, 1, 8'h00);
      chk("t1_hold", 32'(bcd), 32'h12);

      // 2: target 00 fires on the wrap
      cyc(0, 1, 0, 0, 8'h00);
      for (int i = 0; i < 100; i++) cyc(0, 0, 0, 1, 8'h00);
      chk("t2_bcd",  32'(bcd),     32'h00);
      chk("t2_z",    32'(z),       32'h1);
      chk("t2_done", 32'(done),    32'h1);
      chk("t2_run",  32'(running), 32'h0);
      cyc(0, 1, 0, 0, 8'hA3);
      chk("t2_err",   32'(err),  32'h1);
      chk("t2_dkeep", 32'(done), 32'h1);
      cyc(0, 0, 0, 0, 8'h00);

      // 3: invalid target from IDLE
      cyc(1, 0, 0, 0, 8'h00);
      cyc(0, 1, 0, 1, 8'h1A);
      chk("t3_err", 32'(err),     32'h1);
      chk("t3_run", 32'(running), 32'h0);
      chk("t3_bcd", 32'(bcd),     32'h00);
      cyc(0, 0, 0, 1, 8'h00);
      chk("t3_err1", 32'(err), 32'h0);

      // 4: pause / resume
      cyc(0, 1, 0, 0, 8'h50);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'h00);
      cyc(0, 0, 1, 1, 8'h00);
      chk("t4_stop", 32'(bcd),     32'h05);
      chk("t4_prun", 32'(running), 32'h0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'h00);
      chk("t4_hold", 32'(bcd), 32'h05);
      cyc(0, 1, 0, 0, 8'h00);
      cyc(0, 0, 0, 1, 8'h00);
      chk("t4_res", 32'(bcd), 32'h06);
      cyc(0, 1, 0, 1, 8'h99);
      chk("t4_ign", 32'(bcd), 32'h07);

      // 5: auto-restart instance, target 03
      cyc(1, 0, 0, 0, 8'h00);
      cyc(0, 1, 0, 0, 8'h03);
      for (int i = 0; i < 7; i++) begin
         cyc(0, 0, 0, 1, 8'h00);
         chk("t5_bcd",  32'(abcd),  32'(seq5[i]));
         chk("t5_done", 32'(adone), 32'(i == 2 || i == 5));
      end

      // 6: async reset mid-count, then clear beats start
      cyc(1, 0, 0, 0, 8'h00);
      cyc(0, 1, 0, 0, 8'h99);
      for (int i = 0; i < 47; i++) cyc(0, 0, 0, 1, 8'h00);
      chk("t6_bcd", 32'(bcd), 32'h47);
      @(negedge clk);
      tick = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk_zero("t6_arst");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      cyc(0, 0, 0, 1, 8'h00);
      chk("t6_nostart", 32'(bcd), 32'h00);
      cyc(0, 1, 0, 0, 8'h20);
      cyc(0, 0, 0, 1, 8'h00);
      cyc(1, 1, 0, 1, 8'h20);
      chk("t6_clr_run", 32'(running), 32'h0);
      chk("t6_clr_bcd", 32'(bcd),     32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
